data_memory_ctrl: RTL and testbench

- Parametrised, byte-addressable data memory for the load/store stage of the RISC-Net datapath.
- Generalises the fixed 16-bit word/byte memory to configurable data width, depth and read latency.
- Adds a valid/ready request handshake, a registered response with fault signalling, and signed/unsigned byte loads.
- Adds a post-reset hardware clear sequence, so memory contents are defined after reset.

---
 rtl/data_memory_ctrl_if.sv | 28 ++
 rtl/data_memory_ctrl.sv | 137 +++++++++++++
 tb/tb_data_memory_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_ctrl_if.sv
`timescale 1ns/1ps
// Request/response bus for data_memory_ctrl.
// master drives requests and store data; slave returns ready, load data and fault.
interface data_memory_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              rd;
  logic              wn;
  logic [ADDR_W-1:0] address;
  logic [1:0]        mode;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              rsp_valid;
  logic              fault;

  modport master (
    output req_valid, rd, wn, address, mode, write_data,
    input  req_ready, read_data, rsp_valid, fault
  );

  modport slave (
    input  req_valid, rd, wn, address, mode, write_data,
    output req_ready, read_data, rsp_valid, fault
  );
endinterface

// File: rtl/data_memory_ctrl.sv
`timescale 1ns/1ps
// Byte-addressable big-endian data memory: valid/ready requests, pipelined
// responses with fault flag, zero-fill after reset. Ports: clk, rst_n, bus (slave).
module data_memory_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_BYTES = 2048,
  parameter int RD_LATENCY  = 1
) (
  input logic               clk,
  input logic               rst_n,
  data_memory_ctrl_if.slave bus
);

  localparam int NB     = DATA_W / 8;
  localparam int NWORDS = DEPTH_BYTES / NB;
  localparam int PTR_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int IDX_W  = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  typedef enum logic {S_INIT, S_IDLE} state_t;

  state_t            state;
  logic [PTR_W-1:0]  ptr;
  logic              ready_q;
  logic              rsp_q;
  logic              fault_q;
  logic [DATA_W-1:0] rdata_q;

  logic [7:0]        mem [DEPTH_BYTES];

  logic              pv [RD_LATENCY];
  logic              pf [RD_LATENCY];
  logic              pr [RD_LATENCY];
  logic [DATA_W-1:0] pd [RD_LATENCY];

  logic              accept;
  logic              in_range;
  logic              aligned;
  logic              legal;
  int                base;
  logic [DATA_W-1:0] rword;
  logic [7:0]        rbyte;
  logic [DATA_W-1:0] rdata;

  assign accept   = bus.req_valid && ready_q;
  assign in_range = {1'b0, bus.address} < (ADDR_W+1)'(DEPTH_BYTES);
  assign aligned  = (bus.address % ADDR_W'(NB)) == '0;
  assign legal    = (bus.rd ^ bus.wn) && (bus.mode != 2'b11)
                 && in_range && (bus.mode != 2'b00 || aligned);

  // Byte lanes guarded so an illegal request never indexes past the array.
  always_comb begin
    rword = '0;
    base  = int'(bus.address);
    for (int i = 0; i < NB; i++) begin
      if (base + i < DEPTH_BYTES)
        rword[DATA_W-1-8*i -: 8] = mem[IDX_W'(base + i)];
    end
    rbyte = in_range ? mem[IDX_W'(base)] : 8'h00;
    rdata = '0;
    unique case (1'b1)
      (bus.mode == 2'b00): rdata = rword;
      (bus.mode == 2'b01): rdata = {{(DATA_W-8){1'b0}}, rbyte};
      (bus.mode == 2'b10): rdata = {{(DATA_W-8){rbyte[7]}}, rbyte};
      default:             rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      for (int i = 0; i < NB; i++)
        mem[IDX_W'(int'(ptr) * NB + i)] <= 8'h00;
    end else if (rst_n && accept && legal && bus.wn) begin
      if (bus.mode == 2'b00) begin
        for (int i = 0; i < NB; i++)
          mem[IDX_W'(base + i)] <= bus.write_data[DATA_W-1-8*i -: 8];
      end else begin
        mem[IDX_W'(base)] <= bus.write_data[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_INIT;
      ptr     <= '0;
      ready_q <= 1'b0;
      rsp_q   <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pv[i] <= 1'b0;
        pf[i] <= 1'b0;
        pr[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else begin
      case (state)
        S_INIT: begin
          ptr <= ptr + 1'b1;
          if (ptr == PTR_W'(NWORDS - 1)) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        S_IDLE: ready_q <= 1'b1;
      endcase

      pv[0] <= accept;
      pf[0] <= !legal;
      pr[0] <= bus.rd && !bus.wn;
      pd[0] <= rdata;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pf[i] <= pf[i-1];
        pr[i] <= pr[i-1];
        pd[i] <= pd[i-1];
      end

      // Write responses keep the last load value; faults clear it.
      rsp_q <= pv[RD_LATENCY-1];
      if (pv[RD_LATENCY-1]) begin
        fault_q <= pf[RD_LATENCY-1];
        if (pf[RD_LATENCY-1])
          rdata_q <= '0;
        else if (pr[RD_LATENCY-1])
          rdata_q <= pd[RD_LATENCY-1];
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_q;
  assign bus.fault     = fault_q;
  assign bus.read_data = rdata_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
`timescale 1ns/1ps
// Directed bench for data_memory_ctrl: 16-bit/latency-1 and
// 32-bit/latency-3 instances sharing clock and reset.
module tb_data_memory_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_memory_ctrl_if #(.DATA_W(16), .ADDR_W(16)) b1();
  data_memory_ctrl_if #(.DATA_W(32), .ADDR_W(16)) b3();

  data_memory_ctrl #(
    .DATA_W(16), .ADDR_W(16), .DEPTH_BYTES(2048), .RD_LATENCY(1)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  data_memory_ctrl #(
    .DATA_W(32), .ADDR_W(16), .DEPTH_BYTES(2048), .RD_LATENCY(3)
  ) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic idle_bus();
    b1.req_valid = 0; b1.rd = 0; b1.wn = 0;
    b1.address = '0; b1.mode = '0; b1.write_data = '0;
    b3.req_valid = 0; b3.rd = 0; b3.wn = 0;
    b3.address = '0; b3.mode = '0; b3.write_data = '0;
  endtask

  task automatic req1(input logic r, input logic w,
                      input logic [15:0] a, input logic [1:0] m,
                      input logic [15:0] wd, output int lat,
                      output logic [15:0] d, output logic f);
    b1.req_valid = 1; b1.rd = r; b1.wn = w;
    b1.address = a; b1.mode = m; b1.write_data = wd;
    @(posedge clk); #1;
    b1.req_valid = 0; b1.rd = 0; b1.wn = 0;
    lat = 0;
    while (!b1.rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    d = b1.read_data;
    f = b1.fault;
  endtask

  task automatic req3(input logic r, input logic w,
                      input logic [15:0] a, input logic [1:0] m,
                      input logic [31:0] wd, output int lat,
                      output logic [31:0] d, output logic f);
    b3.req_valid = 1; b3.rd = r; b3.wn = w;
    b3.address = a; b3.mode = m; b3.write_data = wd;
    @(posedge clk); #1;
    b3.req_valid = 0; b3.rd = 0; b3.wn = 0;
    lat = 0;
    while (!b3.rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    d = b3.read_data;
    f = b3.fault;
  endtask

  task automatic test_reset();
    int cnt;
    idle_bus();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({b1.req_ready, b1.rsp_valid, b1.fault, b1.read_data} !== 19'h0) begin
      fails++;
      $display("FAIL reset_out16 got %h want 0",
               {b1.req_ready, b1.rsp_valid, b1.fault, b1.read_data});
    end
    tests++;
    if ({b3.req_ready, b3.rsp_valid, b3.fault, b3.read_data} !== 35'h0) begin
      fails++;
      $display("FAIL reset_out32 got %h want 0",
               {b3.req_ready, b3.rsp_valid, b3.fault, b3.read_data});
    end
    rst_n = 1;
    cnt = 0;
    while (b1.req_ready !== 1'b1 && cnt < 5000) begin
      @(posedge clk); #1;
      cnt++;
    end
    tests++;
    if (cnt !== 1024) begin
      fails++;
      $display("FAIL init_cycles got %0d want 1024", cnt);
    end
    tests++;
    if (b3.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL init32_ready got %b want 1", b3.req_ready);
    end
  endtask

  task automatic test_init_read();
    int lat; logic [15:0] d; logic f;
    req1(1, 0, 16'h07FE, 2'b00, 16'h0, lat, d, f);
    tests++;
    if (lat !== 1) begin
      fails++; $display("FAIL init_rd_lat got %0d want 1", lat);
    end
    tests++;
    if ({f, d} !== 17'h0) begin
      fails++; $display("FAIL init_rd got f=%b d=%h want f=0 d=0000", f, d);
    end
  endtask

  task automatic test_word_rw();
    int lat; logic [15:0] d; logic f;
    req1(0, 1, 16'h0010, 2'b00, 16'hA1B2, lat, d, f);
    tests++;
    if ({lat, f, d} !== {32'd1, 1'b0, 16'h0000}) begin
      fails++;
      $display("FAIL wr_rsp got lat=%0d f=%b d=%h want 1 0 0000", lat, f, d);
    end
    req1(1, 0, 16'h0010, 2'b00, 16'h0, lat, d, f);
    tests++;
    if ({f, d} !== {1'b0, 16'hA1B2}) begin
      fails++; $display("FAIL rd_word got f=%b d=%h want 0 a1b2", f, d);
    end
    req1(1, 0, 16'h0011, 2'b01, 16'h0, lat, d, f);
    tests++;
    if ({f, d} !== {1'b0, 16'h00B2}) begin
      fails++; $display("FAIL rd_ubyte got f=%b d=%h want 0 00b2", f, d);
    end
    req1(1, 0, 16'h0010, 2'b10, 16'h0, lat, d, f);
    tests++;
    if ({f, d} !== {1'b0, 16'hFFA1}) begin
      fails++; $display("FAIL rd_sbyte got f=%b d=%h want 0 ffa1", f, d);
    end
  endtask

  task automatic test_back_to_back();
    b1.req_valid = 1; b1.rd = 0; b1.wn = 1;
    b1.address = 16'h0011; b1.mode = 2'b01; b1.write_data = 16'h7F3C;
    @(posedge clk); #1;
    tests++;
    if (b1.rsp_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_early got %b want 0", b1.rsp_valid);
    end
    b1.rd = 1; b1.wn = 0; b1.address = 16'h0010; b1.mode = 2'b00;
    @(posedge clk); #1;
    b1.req_valid = 0; b1.rd = 0;
    tests++;
    if ({b1.rsp_valid, b1.fault, b1.read_data} !== {2'b10, 16'hFFA1}) begin
      fails++;
      $display("FAIL b2b_wr_rsp got v=%b f=%b d=%h want 1 0 ffa1",
               b1.rsp_valid, b1.fault, b1.read_data);
    end
    @(posedge clk); #1;
    tests++;
    if ({b1.rsp_valid, b1.fault, b1.read_data} !== {2'b10, 16'hA13C}) begin
      fails++;
      $display("FAIL b2b_rd_rsp got v=%b f=%b d=%h want 1 0 a13c",
               b1.rsp_valid, b1.fault, b1.read_data);
    end
    @(posedge clk); #1;
    tests++;
    if (b1.rsp_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_tail got %b want 0", b1.rsp_valid);
    end
  endtask

  task automatic test_faults();
    int lat; logic [15:0] d; logic f; logic seen;
    logic        tr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        tw [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] ta [4] = '{16'h0013, 16'h0800, 16'h0010, 16'h0010};
    logic [1:0]  tm [4] = '{2'b00, 2'b01, 2'b00, 2'b11};
    logic [15:0] td [4] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h5555};
    for (int i = 0; i < 4; i++) begin
      req1(tr[i], tw[i], ta[i], tm[i], td[i], lat, d, f);
      tests++;
      if ({lat, f, d} !== {32'd1, 1'b1, 16'h0000}) begin
        fails++;
        $display("FAIL fault_%0d got lat=%0d f=%b d=%h want 1 1 0000",
                 i, lat, f, d);
      end
    end
    b1.req_valid = 0; b1.wn = 1; b1.rd = 0;
    b1.address = 16'h0010; b1.mode = 2'b00; b1.write_data = 16'h0000;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (b1.rsp_valid) seen = 1;
    end
    b1.wn = 0;
    tests++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL novalid_rsp got %b want 0", seen);
    end
    req1(1, 0, 16'h0010, 2'b00, 16'h0, lat, d, f);
    tests++;
    if ({f, d} !== {1'b0, 16'hA13C}) begin
      fails++; $display("FAIL fault_nowrite got f=%b d=%h want 0 a13c", f, d);
    end
  endtask

  task automatic test_latency3();
    int lat; logic [31:0] d; logic f;
    logic        v [8];
    logic [31:0] rdv [8];
    logic        fv [8];
    logic        ev [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    logic [31:0] ed [8] = '{0, 0, 0, 32'hDEADBEEF, 32'h000000AD,
                            32'hFFFFFFDE, 32'h00000000, 0};
    logic        ef [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    logic [15:0] qa [4] = '{16'h0004, 16'h0005, 16'h0004, 16'h0007};
    logic [1:0]  qm [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
    req3(0, 1, 16'h0004, 2'b00, 32'hDEADBEEF, lat, d, f);
    tests++;
    if ({lat, f} !== {32'd3, 1'b0}) begin
      fails++; $display("FAIL l3_wr got lat=%0d f=%b want 3 0", lat, f);
    end
    b3.req_valid = 1; b3.rd = 1; b3.wn = 0;
    b3.address = qa[0]; b3.mode = qm[0];
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k < 3) begin
        b3.address = qa[k+1]; b3.mode = qm[k+1];
      end else begin
        b3.req_valid = 0; b3.rd = 0;
      end
      v[k] = b3.rsp_valid; rdv[k] = b3.read_data; fv[k] = b3.fault;
    end
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (v[k] !== ev[k]) begin
        fails++; $display("FAIL l3_valid_%0d got %b want %b", k, v[k], ev[k]);
      end else if (ev[k] && {fv[k], rdv[k]} !== {ef[k], ed[k]}) begin
        fails++;
        $display("FAIL l3_data_%0d got f=%b d=%h want f=%b d=%h",
                 k, fv[k], rdv[k], ef[k], ed[k]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int lat; int cnt; logic seen;
    logic [31:0] d3; logic [15:0] d1; logic f;
    req3(0, 1, 16'h0008, 2'b00, 32'h11223344, lat, d3, f);
    req1(0, 1, 16'h0020, 2'b00, 16'h5A5A, lat, d1, f);
    req1(1, 0, 16'h0020, 2'b00, 16'h0, lat, d1, f);
    tests++;
    if (d1 !== 16'h5A5A) begin
      fails++; $display("FAIL pre_rst_rd got %h want 5a5a", d1);
    end
    b3.req_valid = 1; b3.rd = 1; b3.address = 16'h0008; b3.mode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    b3.req_valid = 0; b3.rd = 0;
    #2 rst_n = 0;
    #1;
    tests++;
    if ({b3.req_ready, b3.rsp_valid, b3.fault, b3.read_data} !== 35'h0) begin
      fails++;
      $display("FAIL midrst_out got %h want 0",
               {b3.req_ready, b3.rsp_valid, b3.fault, b3.read_data});
    end
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (b3.rsp_valid || b1.rsp_valid) seen = 1;
    end
    rst_n = 1;
    cnt = 0;
    while (b3.req_ready !== 1'b1 && cnt < 5000) begin
      @(posedge clk); #1;
      cnt++;
      if (b3.rsp_valid) seen = 1;
    end
    tests++;
    if (cnt !== 512) begin
      fails++; $display("FAIL init32_cycles got %0d want 512", cnt);
    end
    while (b1.req_ready !== 1'b1 && cnt < 5000) begin
      @(posedge clk); #1;
      cnt++;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL midrst_rsp got %b want 0", seen);
    end
    req3(1, 0, 16'h0008, 2'b00, 32'h0, lat, d3, f);
    tests++;
    if ({lat, f, d3} !== {32'd3, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL post_rst32 got lat=%0d f=%b d=%h want 3 0 0", lat, f, d3);
    end
    req1(1, 0, 16'h0020, 2'b00, 16'h0, lat, d1, f);
    tests++;
    if ({f, d1} !== 17'h0) begin
      fails++; $display("FAIL post_rst16 got f=%b d=%h want 0 0000", f, d1);
    end
  endtask

  initial begin
    test_reset();
    test_init_read();
    test_word_rw();
    test_back_to_back();
    test_faults();
    test_latency3();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
